// File: rtl/peak_pair_sequencer.sv
// Peak-pair sequencer: strobes the min/max peak detector every PERIOD+1 clocks and
// queues the captured {max,min} byte pairs in a 4-deep first-word-fall-through FIFO.
module peak_pair_sequencer #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             CLR,
  input  logic [DIV_W-1:0] PERIOD,
  input  logic [7:0]       PD_DATA,
  output logic             PD_LOAD,
  output logic [15:0]      PAIR_DATA,
  output logic             PAIR_VALID,
  input  logic             PAIR_READY,
  output logic [2:0]       PAIR_COUNT,
  output logic             OVERFLOW,
  output logic [1:0]       DBG_STATE
);

  // Handshake: PAIR_DATA is the FIFO head whenever PAIR_VALID is high; the head is
  // consumed on any rising edge where PAIR_VALID and PAIR_READY are both high.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic              pd_load_q, pd_load_d;
  logic              mcap_q, mcap_d;
  logic [7:0]        max_q, max_d;
  logic [15:0]       mem_q [4];
  logic [15:0]       mem_d [4];
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [DIV_W-1:0]  period_clamped;
  logic [DIV_W-1:0]  cnt_inc;
  logic              at_end;
  logic              fifo_full;
  logic              do_pop;
  logic              do_push;

  assign period_clamped = (PERIOD < MIN_PERIOD) ? MIN_PERIOD : PERIOD;
  assign cnt_inc        = cnt_q + DIV_W'(1);
  assign at_end         = (state_q != S_IDLE) && (cnt_q == period_q);

  // Interval sequencing; the strobe flop is set one cycle ahead so PD_LOAD is
  // high exactly in the cycle where cnt equals period_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    pd_load_d = 1'b0;
    mcap_d    = 1'b0;
    max_d     = max_q;
    if (!ENABLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d  = S_PRIME;
      cnt_d    = '0;
      period_d = period_clamped;
    end else if (at_end) begin
      cnt_d    = '0;
      period_d = period_clamped;
      state_d  = S_RUN;
      // The priming strobe only initialises the detector, so its pair is dropped.
      if (state_q == S_RUN) begin
        max_d  = PD_DATA;
        mcap_d = 1'b1;
      end
    end else begin
      cnt_d     = cnt_inc;
      pd_load_d = (cnt_inc == period_q);
    end
  end

  assign fifo_full = (count_q == 3'd4);
  assign do_pop    = (count_q != 3'd0) && PAIR_READY;
  assign do_push   = mcap_q && (!fifo_full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (CLR) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = {max_q, PD_DATA};
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      if (mcap_q && fifo_full && !do_pop) begin
        ovf_d = 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= MIN_PERIOD;
      pd_load_q <= 1'b0;
      mcap_q    <= 1'b0;
      max_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pd_load_q <= pd_load_d;
      mcap_q    <= mcap_d;
      max_q     <= max_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign PD_LOAD    = pd_load_q;
  assign PAIR_VALID = (count_q != 3'd0);
  assign PAIR_DATA  = PAIR_VALID ? mem_q[rd_ptr_q] : 16'h0000;
  assign PAIR_COUNT = count_q;
  assign OVERFLOW   = ovf_q;
  assign DBG_STATE  = state_q;

endmodule

// File: doc/peak_pair_sequencer.md
# peak_pair_sequencer

Controller and collector on the far side of the min/max peak detector in the sampling path. It issues the detector's interval strobe at a programmable decimation period and captures the max/min byte pair the detector presents around each strobe. Each pair is packed into a 16-bit word and buffered in a 4-entry FIFO. The FIFO is drained by the sample-memory writer over a valid/ready handshake.

## Interface
- DIV_W, 16: width of the decimation period register.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run decimation; level-sensitive.
- CLR  in  1  synchronous flush of the FIFO and OVERFLOW.
- PERIOD  in  DIV_W  interval length minus 1, in clocks. Values below 2 are treated as 2.
- PD_DATA  in  8  peak detector output bus.
- PD_LOAD  out  1  one-cycle interval strobe to the peak detector; driven from a flop.
- PAIR_DATA  out  16  FIFO head, packed as {max[15:8], min[7:0]}.
- PAIR_VALID  out  1  FIFO not empty.
- PAIR_READY  in  1  consumer accepts the head word.
- PAIR_COUNT  out  3  FIFO occupancy, 0..4.
- OVERFLOW  out  1  sticky flag: a pair was dropped because the FIFO was full.

## Operation
- **Detector contract:**
  - In the cycle PD_LOAD is high, PD_DATA carries the max of the ending interval.
  - In the following cycle, PD_DATA carries the min of the same interval.
- **State machine:** IDLE, PRIME, RUN.
  - IDLE: cnt held at 0, PD_LOAD = 0.
  - IDLE -> PRIME on the first edge with ENABLE = 1. At that edge: cnt <= 0, period_q <= max(PERIOD, 2).
  - PRIME: cnt increments each cycle. When cnt == period_q:
    - PD_LOAD is high;
    - cnt wraps to 0;
    - period_q reloads from PERIOD;
    - state -> RUN.
    - This first pair is discarded, because the detector is not yet initialised.
  - RUN: same counting behaviour. When cnt == period_q, PD_LOAD is high and the max is captured.
  - One cycle after each RUN strobe, the min capture flag (mcap) is set. At the edge ending that cycle, {max_q, PD_DATA} is pushed to the FIFO.
  - Any state -> IDLE on an edge with ENABLE = 0. The partial interval is discarded.
    - If mcap is pending at that edge, the push still completes.
- **PERIOD changes:** take effect only at the next strobe (period_q reload). Because period_q >= 2, mcap never coincides with a strobe.
- **FIFO:** 4 entries, first-word-fall-through. PAIR_DATA is valid whenever PAIR_VALID = 1.
  - Pop occurs on an edge with PAIR_VALID & PAIR_READY.
  - Push while full, with no pop on the same edge: the new pair is dropped and OVERFLOW is set.
  - Push while full, with a pop on the same edge: the push is accepted and the count stays at 4.
  - Push and pop while not full: the count is unchanged.
  - Contents are retained and readable in IDLE.
- **CLR:** on the edge where CLR = 1, occupancy and OVERFLOW go to 0. A push on that same edge is discarded. The sequencer state is unaffected.
- **Width rules:**
  - cnt and period_q are DIV_W bits.
  - Maximum interval is 2^DIV_W clocks.
  - No arithmetic is performed on data bytes.

## Timing
- **Reset:** asserting RST_N low asynchronously forces all outputs and state to zero:
  - state = IDLE, cnt = 0, period_q = 2;
  - PD_LOAD = 0, PAIR_VALID = 0, PAIR_DATA = 16'h0000, PAIR_COUNT = 0, OVERFLOW = 0.
  - Reset mid-interval or mid-capture abandons everything in progress.
- **Strobe timing:**
  - Number the cycles after the enabling edge from 1; cnt = 0 in cycle 1.
  - PD_LOAD is high in cycles P+1, 2P+2, 3P+3, ..., where P = period_q.
- **Capture timing:**
  - Max is sampled at the edge ending the PD_LOAD cycle.
  - Min is sampled at the next edge, which is also the push edge.
  - PAIR_VALID rises in the cycle after the push. For the first pair, from an empty FIFO, this is cycle 2P+4.
- **Throughput:** 1 pair per P+1 clocks. The consumer must sustain that rate, or OVERFLOW is set.

## Test plan
- **Basic capture.** PERIOD = 4; ENABLE at edge 0; PD_DATA = 8'hC3 in PD_LOAD cycles and 8'h1A in the following cycles.
  - Required: PD_LOAD pulses in cycles 5, 10, 15, ....
  - First PAIR_VALID in cycle 12, with PAIR_DATA = 16'hC31A.
  - The prime pair from cycle 5 never appears.
- **Period clamp and reload.** PERIOD = 0 at enable.
  - Required: strobes 3 cycles apart.
  - Change PERIOD to 9 mid-interval: the next gap is still 3 cycles, then 10-cycle gaps.
- **Overflow.** PERIOD = 2; PAIR_READY = 0 for 6 strobes after priming.
  - Required: PAIR_COUNT = 4 and OVERFLOW = 1 after the 5th pair. The FIFO holds pairs 1-4 in order.
  - Assert CLR: PAIR_COUNT = 0, OVERFLOW = 0.
- **Full plus simultaneous pop.** FIFO full; PAIR_READY = 1 on a push edge.
  - Required: the count stays at 4, OVERFLOW stays 0, and the head advances to the next pair.
- **Disable mid-capture.** Drop ENABLE in the cycle after a RUN strobe.
  - Required: the pair is still pushed and PD_LOAD stays 0 afterwards.
  - Re-enable: priming repeats, and no pair is emitted until the second strobe.
- **Async reset mid-operation.** Pull RST_N low between edges while PAIR_COUNT = 3.
  - Required: all outputs go to 0 immediately. After release with ENABLE = 1, behaviour matches the basic-capture scenario.
